// File: rtl/fetch_seq_pkg.sv
// ---------------------------------------------------------------------------
// fetch_seq_pkg
//
// Purpose:
//   Shared definitions for the instruction fetch sequencer and the downstream
//   instruction classifier.
//
// Contents:
//   INST_W      - instruction word width (MIPS, fixed at 32)
//   OP_RTYPE    - primary opcode of R-type instructions
//   OP_J        - primary opcode of J
//   OP_JAL      - primary opcode of JAL
//   seq_state_t - fetch sequencer FSM states (IDLE, RUN, DRAIN, DONE)
//   opcode_of() - extracts the 6-bit primary opcode from an instruction word
// ---------------------------------------------------------------------------
package fetch_seq_pkg;

    localparam int INST_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic logic [5:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[31:26];
    endfunction

endpackage

// File: rtl/inst_skid_buf.sv
// ---------------------------------------------------------------------------
// inst_skid_buf
//
// Purpose:
//   Two-entry FIFO that holds {pc, instruction} pairs between the ROM
//   response and the classifier handshake. The head entry is a register, so
//   the data presented downstream never has a combinational path from the
//   ROM. Simultaneous push and pop keep the occupancy unchanged.
//
// Parameters:
//   DATA_W    - width of one entry ({pc, inst})
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset, empties the buffer
//   push      - write push_data this cycle
//   push_data - entry to write
//   pop       - consumer ready; an entry is removed only when valid is high
//   valid     - buffer not empty
//   head_data - oldest entry (registered)
//   occupancy - number of stored entries, 0..2
// ---------------------------------------------------------------------------
module inst_skid_buf #(
    parameter int DATA_W = fetch_seq_pkg::INST_W + 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occupancy
);
    import fetch_seq_pkg::*;

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        count_q;
    logic              do_pop;
    logic              do_push;

    // A pop only happens when something is stored; a push into a full
    // buffer is accepted only if the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= push_data;
                    end else begin
                        tail_q <= push_data;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy stays the same; the new entry goes behind
                    // whatever remains after the head leaves.
                    if (count_q == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid     = (count_q != 2'd0);
    assign head_data = head_q;
    assign occupancy = count_q;

endmodule

// File: rtl/inst_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// inst_fetch_sequencer
//
// Purpose:
//   Walks a program counter through a synchronous instruction ROM for a
//   programmed number of instructions and hands each word to the classifier
//   over a valid/ready handshake. A read is only issued when the 2-entry
//   buffer is guaranteed room for its response, so backpressure never loses
//   or overwrites an instruction.
//
// Configuration:
//   SEQ_STALL_CNT_EN - when defined, stall_cycles counts busy cycles in which
//                      an instruction is offered but not accepted (saturating
//                      at 16'hFFFF, cleared on start). When undefined,
//                      stall_cycles is tied to zero.
//
// Parameters:
//   ADDR_W - ROM address / PC width; the PC wraps modulo 2^ADDR_W
//   INST_W - instruction width
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   start        - run request, honoured only when idle
//   base_addr    - first PC of the run, latched on start
//   length       - instructions to issue (0..2^ADDR_W), latched on start
//   busy         - high while reading or draining
//   done         - one-cycle completion pulse
//   imem_en      - ROM read strobe
//   imem_addr    - ROM read address
//   imem_rdata   - ROM data, valid one cycle after imem_en
//   inst_valid   - instruction offered to the classifier
//   inst_data    - instruction word
//   inst_pc      - PC of inst_data
//   inst_ready   - classifier accepts the offered instruction
//   issued_count - transfers completed in the current or last run
//   stall_cycles - stall counter (see Configuration)
// ---------------------------------------------------------------------------
module inst_fetch_sequencer #(
    parameter int ADDR_W = 5,
    parameter int INST_W = fetch_seq_pkg::INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [ADDR_W:0]   issued_count,
    output logic [15:0]       stall_cycles
);
    import fetch_seq_pkg::*;

    localparam int ENTRY_W = ADDR_W + INST_W;

    seq_state_t state;
    seq_state_t state_next;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  rd_pc;
    logic [ADDR_W:0]    remaining;
    logic [ADDR_W:0]    issued_q;
    logic               in_flight;
    logic               read_en;
    logic               transfer;
    logic               accept;
    logic               credit;
    logic [1:0]         occupancy;
    logic [2:0]         pending;
    logic [ENTRY_W-1:0] head_data;

    assign transfer = inst_valid && inst_ready;
    assign accept   = (state == IDLE) && start;

    // Buffered plus in-flight words must never exceed the buffer depth once
    // the outstanding read lands. A transfer in this cycle frees one slot,
    // which is what sustains one instruction per cycle.
    assign pending = {1'b0, occupancy} + {2'b00, in_flight};
    assign credit  = (pending <= 3'd1) || ((pending == 3'd2) && transfer);
    assign read_en = (state == RUN) && (remaining != '0) && credit;

    assign imem_en   = read_en;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (read_en && (remaining == {{ADDR_W{1'b0}}, 1'b1})) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((occupancy == 2'd0) && !in_flight) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // rd_pc travels alongside the outstanding read so the response can be
    // tagged with its address when it lands in the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            rd_pc     <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            issued_q  <= '0;
        end else begin
            in_flight <= read_en;
            if (read_en) begin
                rd_pc <= pc;
            end

            if (accept) begin
                pc        <= base_addr;
                remaining <= length;
            end else if (read_en) begin
                pc        <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                remaining <= remaining - {{ADDR_W{1'b0}}, 1'b1};
            end

            if (accept) begin
                issued_q <= '0;
            end else if (transfer) begin
                issued_q <= issued_q + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    inst_skid_buf #(
        .DATA_W (ENTRY_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight),
        .push_data ({rd_pc, imem_rdata}),
        .pop       (inst_ready),
        .valid     (inst_valid),
        .head_data (head_data),
        .occupancy (occupancy)
    );

    assign inst_pc      = head_data[ENTRY_W-1:INST_W];
    assign inst_data    = head_data[INST_W-1:0];
    assign issued_count = issued_q;

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'd0;
        end else if (accept) begin
            stall_q <= 16'd0;
        end else if (busy && inst_valid && !inst_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_sequencer
//
// Self-checking bench for inst_fetch_sequencer (ADDR_W=5, INST_W=32).
// A reference model builds, for each run, the queue of {pc, word} pairs the
// classifier must receive; a negedge monitor checks every read address,
// every transfer, held data under backpressure and the outstanding-word
// bound. Runs come from a vector table, hand-written corner sequences and
// random runs. Define SEQ_STALL_CNT_EN to also check the stall counter.
// ---------------------------------------------------------------------------
module tb_inst_fetch_sequencer;
    import fetch_seq_pkg::*;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic [31:0]   inst_data;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;
    logic [AW:0]   issued_count;
    logic [15:0]   stall_cycles;

    inst_fetch_sequencer #(
        .ADDR_W (AW),
        .INST_W (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .issued_count (issued_count),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM; outside a read cycle the data bus carries junk.
    logic [31:0] rom [32];
    initial imem_rdata = 32'd0;
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom[imem_addr];
        else         imem_rdata <= $urandom;
    end

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   data;
    } entry_t;

    entry_t        exp_q[$];
    entry_t        mon_e;
    logic [AW-1:0] run_base;
    logic [AW:0]   run_len;
    int            reads;
    int            transfers;
    int            stall_exp;
    int            done_seen;
    int            valid_cycles;
    logic          prev_stalled = 1'b0;
    logic [AW-1:0] prev_pc;
    logic [31:0]   prev_data;

    task automatic modelReset(input logic [AW-1:0] b, input logic [AW:0] l);
        logic [AW-1:0] p;
        exp_q.delete();
        for (int i = 0; i < int'(l); i++) begin
            p = AW'(b + AW'(i));
            exp_q.push_back('{pc: p, data: rom[p]});
        end
        run_base     = b;
        run_len      = l;
        reads        = 0;
        transfers    = 0;
        stall_exp    = 0;
        done_seen    = 0;
        valid_cycles = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled) begin
                checkOutput("hold_valid", 64'(inst_valid), 64'd1);
                checkOutput("hold_pc", 64'(inst_pc), 64'(prev_pc));
                checkOutput("hold_data", 64'(inst_data), 64'(prev_data));
            end
            if (inst_valid) valid_cycles++;
            if (imem_en) begin
                checkOutput("read_addr", 64'(imem_addr), 64'(AW'(run_base + AW'(reads))));
                checkOutput("read_within_len", 64'(reads < int'(run_len)), 64'd1);
                reads++;
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_transfer", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("xfer_pc", 64'(inst_pc), 64'(mon_e.pc));
                    checkOutput("xfer_data", 64'(inst_data), 64'(mon_e.data));
                end
                transfers++;
            end
            if (imem_en || inst_valid)
                checkOutput("outstanding_le2", 64'((reads - transfers) <= 2), 64'd1);
            if (busy && inst_valid && !inst_ready) stall_exp++;
            if (done) done_seen++;
            prev_stalled = inst_valid && !inst_ready;
            prev_pc      = inst_pc;
            prev_data    = inst_data;
        end
    end

    function automatic logic readyFor(input int mode, input int k);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[k % 4];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Starts a run from IDLE and returns once done has been seen (or the
    // cycle budget expired), with the DUT back in IDLE.
    task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] l,
                                 input int mode, input bit inject_start);
        bit got_done;
        @(posedge clk);
        #1;
        modelReset(b, l);
        base_addr  = b;
        length     = l;
        start      = 1'b1;
        inst_ready = readyFor(mode, 0);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        length    = (AW+1)'($urandom);
        got_done  = 1'b0;
        for (int k = 1; k < 400 && !got_done; k++) begin
            inst_ready = readyFor(mode, k);
            if (inject_start && k == 3) begin
                start     = 1'b1;
                base_addr = AW'(b + AW'(16));
                length    = (AW+1)'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) got_done = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (!got_done) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic endChecks(input string tag, input logic [AW:0] exp_issued, input int exp_done);
        repeat (2) @(negedge clk);
        checkOutput({tag, "_issued"}, 64'(issued_count), 64'(exp_issued));
        checkOutput({tag, "_done_pulses"}, 64'(done_seen), 64'(exp_done));
        checkOutput({tag, "_left_in_model"}, 64'(exp_q.size()), 64'd0);
        checkOutput({tag, "_reads"}, 64'(reads), 64'(exp_issued));
        checkOutput({tag, "_busy_idle"}, 64'(busy), 64'd0);
`ifdef SEQ_STALL_CNT_EN
        checkOutput({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(stall_exp));
`else
        checkOutput({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd0);
`endif
        if (exp_issued == '0) checkOutput({tag, "_valid_cycles"}, 64'(valid_cycles), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_imem_en"}, 64'(imem_en), 64'd0);
        checkOutput({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        checkOutput({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
        checkOutput({tag, "_inst_data"}, 64'(inst_data), 64'd0);
        checkOutput({tag, "_inst_pc"}, 64'(inst_pc), 64'd0);
        checkOutput({tag, "_issued"}, 64'(issued_count), 64'd0);
        checkOutput({tag, "_stall"}, 64'(stall_cycles), 64'd0);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            mode;
        bit            inject;
        logic [AW:0]   exp_issued;
        int            exp_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit got;
        logic [5:0] ops [4];

        vecs[0] = '{base: 5'd0,  len: 6'd8,  mode: 0, inject: 1'b0, exp_issued: 6'd8,  exp_done: 1};
        vecs[1] = '{base: 5'd30, len: 6'd4,  mode: 0, inject: 1'b0, exp_issued: 6'd4,  exp_done: 1};
        vecs[2] = '{base: 5'd9,  len: 6'd0,  mode: 2, inject: 1'b0, exp_issued: 6'd0,  exp_done: 1};
        vecs[3] = '{base: 5'd0,  len: 6'd8,  mode: 1, inject: 1'b0, exp_issued: 6'd8,  exp_done: 1};
        vecs[4] = '{base: 5'd4,  len: 6'd8,  mode: 0, inject: 1'b1, exp_issued: 6'd8,  exp_done: 1};
        vecs[5] = '{base: 5'd31, len: 6'd32, mode: 2, inject: 1'b0, exp_issued: 6'd32, exp_done: 1};
        vecs[6] = '{base: 5'd17, len: 6'd1,  mode: 1, inject: 1'b0, exp_issued: 6'd1,  exp_done: 1};

        ops[0] = OP_RTYPE;
        ops[1] = OP_J;
        ops[2] = OP_JAL;
        ops[3] = 6'h23;
        for (int i = 0; i < 32; i++) rom[i] = {ops[i % 4], 26'($urandom)};

        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        length     = '0;
        inst_ready = 1'b0;
        modelReset(5'd0, 6'd0);

        repeat (2) @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Run of 8 from address 0 with exact first-word latency
        $display("[TB] run 8 from 0, latency");
        @(posedge clk);
        #1;
        modelReset(5'd0, 6'd8);
        base_addr  = 5'd0;
        length     = 6'd8;
        start      = 1'b1;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("lat_en_e0", 64'(imem_en), 64'd1);
        checkOutput("lat_addr_e0", 64'(imem_addr), 64'd0);
        checkOutput("lat_valid_e0", 64'(inst_valid), 64'd0);
        checkOutput("lat_busy_e0", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("lat_valid_e1", 64'(inst_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("stream_valid", 64'(inst_valid), 64'd1);
            checkOutput("stream_pc", 64'(inst_pc), 64'(i));
        end
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) checkOutput("t1_done_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        endChecks("t1", 6'd8, 1);

        // length 0: done in the cycle right after the accepting edge
        $display("[TB] length 0");
        @(posedge clk);
        #1;
        modelReset(5'd7, 6'd0);
        base_addr = 5'd7;
        length    = 6'd0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("len0_done", 64'(done), 64'd1);
        checkOutput("len0_busy", 64'(busy), 64'd0);
        checkOutput("len0_imem_en", 64'(imem_en), 64'd0);
        @(posedge clk);
        #1;
        endChecks("len0", 6'd0, 1);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            $display("[TB] vector %0d base=%0d len=%0d mode=%0d", v, vecs[v].base, vecs[v].len, vecs[v].mode);
            applyStimulus(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].inject);
            endChecks($sformatf("vec%0d", v), vecs[v].exp_issued, vecs[v].exp_done);
        end

        // Reset in cycle 4 of a length-8 run
        $display("[TB] reset mid-run");
        @(posedge clk);
        #1;
        modelReset(5'd0, 6'd8);
        base_addr  = 5'd0;
        length     = 6'd8;
        start      = 1'b1;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_no_done", 64'(done_seen), 64'd0);
        checkOutput("midrst_idle", 64'(busy), 64'd0);
        applyStimulus(5'd12, 6'd5, 0, 1'b0);
        endChecks("after_rst", 6'd5, 1);

        // Random runs
        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] rb;
            logic [AW:0]   rl;
            rb = AW'($urandom_range(0, 31));
            rl = (AW+1)'($urandom_range(0, 32));
            $display("[TB] random run %0d base=%0d len=%0d", r, rb, rl);
            applyStimulus(rb, rl, 2, 1'b0);
            endChecks($sformatf("rand%0d", r), rl, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
